// File: rtl/mem_arbiter.sv
// mem_arbiter: merges the icache and dcache memory-side ports onto one main-memory port.
// Latency: zero-cycle combinational pass-through for requests, write beats and responses.
// Backpressure: mem_req_ready/mem_req_data_ready go only to the current owner; reads also
//   stall while MAX_OUTSTANDING reads are in flight. Responses cannot be backpressured.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   ic_req_* / dc_*     per-cache request (valid/ready/addr/rw), write beat
//                       (data_valid/data_ready/bits/mask) and read response (resp_valid/data)
//   mem_req_*           merged request and write-beat channel toward main memory
//   mem_resp_*          in-order read responses from main memory
//   spurious_resp       sticky flag: a response arrived while no read was outstanding
module mem_arbiter #(
  parameter int ADDR_BITS       = 28,
  parameter int DATA_BITS       = 128,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                   clk,
  input  logic                   reset,

  input  logic                   ic_req_valid,
  output logic                   ic_req_ready,
  input  logic [ADDR_BITS-1:0]   ic_req_addr,
  input  logic                   ic_req_rw,
  input  logic                   ic_req_data_valid,
  output logic                   ic_req_data_ready,
  input  logic [DATA_BITS-1:0]   ic_req_data_bits,
  input  logic [DATA_BITS/8-1:0] ic_req_data_mask,
  output logic                   ic_resp_valid,
  output logic [DATA_BITS-1:0]   ic_resp_data,

  input  logic                   dc_req_valid,
  output logic                   dc_req_ready,
  input  logic [ADDR_BITS-1:0]   dc_req_addr,
  input  logic                   dc_req_rw,
  input  logic                   dc_req_data_valid,
  output logic                   dc_req_data_ready,
  input  logic [DATA_BITS-1:0]   dc_req_data_bits,
  input  logic [DATA_BITS/8-1:0] dc_req_data_mask,
  output logic                   dc_resp_valid,
  output logic [DATA_BITS-1:0]   dc_resp_data,

  output logic                   mem_req_valid,
  input  logic                   mem_req_ready,
  output logic [ADDR_BITS-1:0]   mem_req_addr,
  output logic                   mem_req_rw,
  output logic                   mem_req_data_valid,
  input  logic                   mem_req_data_ready,
  output logic [DATA_BITS-1:0]   mem_req_data_bits,
  output logic [DATA_BITS/8-1:0] mem_req_data_mask,
  input  logic                   mem_resp_valid,
  input  logic [DATA_BITS-1:0]   mem_resp_data,

  output logic                   spurious_resp
);

  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_HOLD  = 2'd1;
  localparam logic [1:0] S_WDATA = 2'd2;

  // Client encoding, shared by owner, round-robin pointer and read tags.
  localparam logic CL_IC = 1'b0;
  localparam logic CL_DC = 1'b1;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]                 state_q, state_d;
  logic                       owner_q, owner_d;
  logic                       rr_last_q, rr_last_d;
  // Write beat already delivered ahead of its request handshake.
  logic                       data_done_q, data_done_d;

  logic [MAX_OUTSTANDING-1:0] tag_q;
  logic [PTR_W-1:0]           wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]           count_q;
  logic                       spurious_q;

  // ---------------------------------------------------------------------------
  // Owner selection and owner-side muxing
  // ---------------------------------------------------------------------------
  logic                   owner_sel;
  logic                   own_valid;
  logic                   own_rw;
  logic                   own_data_valid;
  logic [ADDR_BITS-1:0]   own_addr;
  logic [DATA_BITS-1:0]   own_data_bits;
  logic [DATA_BITS/8-1:0] own_data_mask;

  // Only IDLE arbitrates; HOLD and WDATA keep the latched owner so a stalled
  // request or an open write beat cannot be stolen by the other cache.
  always_comb begin
    owner_sel = owner_q;
    if (state_q == S_IDLE) begin
      if (ic_req_valid && dc_req_valid) begin
        owner_sel = ~rr_last_q;
      end else if (dc_req_valid) begin
        owner_sel = CL_DC;
      end else begin
        owner_sel = CL_IC;
      end
    end
  end

  assign own_valid      = (owner_sel == CL_DC) ? dc_req_valid      : ic_req_valid;
  assign own_rw         = (owner_sel == CL_DC) ? dc_req_rw         : ic_req_rw;
  assign own_data_valid = (owner_sel == CL_DC) ? dc_req_data_valid : ic_req_data_valid;
  assign own_addr       = (owner_sel == CL_DC) ? dc_req_addr       : ic_req_addr;
  assign own_data_bits  = (owner_sel == CL_DC) ? dc_req_data_bits  : ic_req_data_bits;
  assign own_data_mask  = (owner_sel == CL_DC) ? dc_req_data_mask  : ic_req_data_mask;

  // ---------------------------------------------------------------------------
  // Tag FIFO status (registered count only; a same-cycle pop does not free a slot)
  // ---------------------------------------------------------------------------
  logic fifo_full;
  logic fifo_empty;
  logic head_tag;

  assign fifo_full  = (count_q == CNT_W'(MAX_OUTSTANDING));
  assign fifo_empty = (count_q == '0);
  assign head_tag   = tag_q[rd_ptr_q];

  // ---------------------------------------------------------------------------
  // Request channel
  // ---------------------------------------------------------------------------
  logic req_phase;
  logic req_ok;
  logic req_hs;

  assign req_phase = !reset && ((state_q == S_IDLE) || (state_q == S_HOLD));
  assign req_ok    = req_phase && own_valid && !(!own_rw && fifo_full);
  assign req_hs    = req_ok && mem_req_ready;

  assign mem_req_valid = req_ok;
  assign mem_req_addr  = own_addr;
  assign mem_req_rw    = own_rw;
  assign ic_req_ready  = req_hs && (owner_sel == CL_IC);
  assign dc_req_ready  = req_hs && (owner_sel == CL_DC);

  // ---------------------------------------------------------------------------
  // Write-data channel
  // ---------------------------------------------------------------------------
  logic data_open;
  logic data_hs;

  // Before the request handshake the beat may go early, but only once and only
  // for a write owner; in WDATA the owner's beat channel is connected unconditionally.
  assign data_open = !reset &&
                     ((state_q == S_WDATA) ||
                      (req_phase && own_valid && own_rw && !data_done_q));

  assign mem_req_data_valid = data_open && own_data_valid;
  assign mem_req_data_bits  = own_data_bits;
  assign mem_req_data_mask  = own_data_mask;
  assign data_hs            = mem_req_data_valid && mem_req_data_ready;
  assign ic_req_data_ready  = data_open && mem_req_data_ready && (owner_sel == CL_IC);
  assign dc_req_data_ready  = data_open && mem_req_data_ready && (owner_sel == CL_DC);

  // ---------------------------------------------------------------------------
  // Response routing
  // ---------------------------------------------------------------------------
  logic resp_hit;
  logic push;
  logic pop;

  assign resp_hit      = !reset && mem_resp_valid && !fifo_empty;
  assign ic_resp_valid = resp_hit && (head_tag == CL_IC);
  assign dc_resp_valid = resp_hit && (head_tag == CL_DC);
  assign ic_resp_data  = mem_resp_data;
  assign dc_resp_data  = mem_resp_data;
  assign spurious_resp = spurious_q;

  assign push = req_hs && !own_rw;
  assign pop  = resp_hit;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_last_d   = rr_last_q;
    data_done_d = data_done_q;

    case (state_q)
      S_IDLE, S_HOLD: begin
        if (req_hs) begin
          rr_last_d   = owner_sel;
          owner_d     = owner_sel;
          data_done_d = 1'b0;
          if (own_rw && !(data_hs || data_done_q)) begin
            state_d = S_WDATA;
          end else begin
            state_d = S_IDLE;
          end
        end else if (own_valid) begin
          state_d = S_HOLD;
          owner_d = owner_sel;
          if (data_hs) begin
            data_done_d = 1'b1;
          end
        end else begin
          // Nothing pending, or the HOLD owner withdrew its request.
          state_d     = S_IDLE;
          data_done_d = 1'b0;
        end
      end

      S_WDATA: begin
        if (data_hs) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d     = S_IDLE;
        data_done_d = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      owner_q     <= CL_IC;
      rr_last_q   <= CL_IC;
      data_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_last_q   <= rr_last_d;
      data_done_q <= data_done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tag_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      spurious_q <= 1'b0;
    end else begin
      if (push) begin
        tag_q[wr_ptr_q] <= owner_sel;
        wr_ptr_q        <= (wr_ptr_q == PTR_W'(MAX_OUTSTANDING - 1)) ? '0
                                                                      : wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == PTR_W'(MAX_OUTSTANDING - 1)) ? '0
                                                               : rd_ptr_q + PTR_W'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + CNT_W'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CNT_W'(1);
      end
      if (mem_resp_valid && fifo_empty) begin
        spurious_q <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Structural invariants
  // ---------------------------------------------------------------------------
  a_one_req_ready: assert property (@(posedge clk) disable iff (reset)
    !(ic_req_ready && dc_req_ready));
  a_one_resp: assert property (@(posedge clk) disable iff (reset)
    !(ic_resp_valid && dc_resp_valid));
  a_count_bound: assert property (@(posedge clk) disable iff (reset)
    count_q <= CNT_W'(MAX_OUTSTANDING));
  a_no_req_in_wdata: assert property (@(posedge clk) disable iff (reset)
    (state_q == S_WDATA) |-> !mem_req_valid);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vector table plus hand-written multi-cycle sequences for mem_arbiter.
// Latency: inputs driven at negedge, outputs sampled 1 time unit later.
// Backpressure: mem_req_ready / mem_req_data_ready driven directly by the vectors.
module tb_mem_arbiter;

  localparam int AB = 28;
  localparam int DB = 128;
  localparam int MB = DB / 8;

  localparam logic [AB-1:0] IC_ADDR = 28'h0001000;
  localparam logic [AB-1:0] DC_ADDR = 28'h0000040;
  localparam logic [DB-1:0] IC_WD   = {4{32'h1111_1111}};
  localparam logic [DB-1:0] DC_WD   = {4{32'h2222_2222}};
  localparam logic [MB-1:0] IC_MK   = 16'h00FF;
  localparam logic [MB-1:0] DC_MK   = 16'hFF00;
  localparam logic [DB-1:0] RSP_D   = {4{32'hDEAD_BEEF}};

  logic clk = 1'b0;
  logic reset;

  logic          ic_req_valid, ic_req_ready, ic_req_rw, ic_req_data_valid, ic_req_data_ready;
  logic [AB-1:0] ic_req_addr;
  logic [DB-1:0] ic_req_data_bits, ic_resp_data;
  logic [MB-1:0] ic_req_data_mask;
  logic          ic_resp_valid;

  logic          dc_req_valid, dc_req_ready, dc_req_rw, dc_req_data_valid, dc_req_data_ready;
  logic [AB-1:0] dc_req_addr;
  logic [DB-1:0] dc_req_data_bits, dc_resp_data;
  logic [MB-1:0] dc_req_data_mask;
  logic          dc_resp_valid;

  logic          mem_req_valid, mem_req_ready, mem_req_rw;
  logic          mem_req_data_valid, mem_req_data_ready;
  logic [AB-1:0] mem_req_addr;
  logic [DB-1:0] mem_req_data_bits, mem_resp_data;
  logic [MB-1:0] mem_req_data_mask;
  logic          mem_resp_valid;
  logic          spurious_resp;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_BITS(AB), .DATA_BITS(DB), .MAX_OUTSTANDING(4)) dut (
    .clk(clk), .reset(reset),
    .ic_req_valid(ic_req_valid), .ic_req_ready(ic_req_ready), .ic_req_addr(ic_req_addr),
    .ic_req_rw(ic_req_rw), .ic_req_data_valid(ic_req_data_valid),
    .ic_req_data_ready(ic_req_data_ready), .ic_req_data_bits(ic_req_data_bits),
    .ic_req_data_mask(ic_req_data_mask), .ic_resp_valid(ic_resp_valid),
    .ic_resp_data(ic_resp_data),
    .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready), .dc_req_addr(dc_req_addr),
    .dc_req_rw(dc_req_rw), .dc_req_data_valid(dc_req_data_valid),
    .dc_req_data_ready(dc_req_data_ready), .dc_req_data_bits(dc_req_data_bits),
    .dc_req_data_mask(dc_req_data_mask), .dc_resp_valid(dc_resp_valid),
    .dc_resp_data(dc_resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_rw(mem_req_rw),
    .mem_req_data_valid(mem_req_data_valid), .mem_req_data_ready(mem_req_data_ready),
    .mem_req_data_bits(mem_req_data_bits), .mem_req_data_mask(mem_req_data_mask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .spurious_resp(spurious_resp)
  );

  // Inputs: rst icv icrw icdv dcv dcrw dcdv mrr mdr rspv
  // Expect: mv icr dcr mdv icdr dcdr icrv dcrv sp, addr (checked when mv=1)
  typedef struct packed {
    logic rst, icv, icrw, icdv, dcv, dcrw, dcdv, mrr, mdr, rspv;
    logic e_mv, e_icr, e_dcr, e_mdv, e_icdr, e_dcdr, e_icrv, e_dcrv, e_sp;
    logic [AB-1:0] e_addr;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string nm, input logic [DB-1:0] act, input logic [DB-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic [9:0] in, input logic [8:0] ex, input logic [AB-1:0] a);
    vecs.push_back({in, ex, a});
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clr();
    ic_req_valid = 0; ic_req_rw = 0; ic_req_data_valid = 0;
    dc_req_valid = 0; dc_req_rw = 0; dc_req_data_valid = 0;
    mem_req_ready = 0; mem_req_data_ready = 0; mem_resp_valid = 0;
    mem_resp_data = '0;
  endtask

  task automatic do_reset();
    tick(); reset = 1; clr();
    tick(); reset = 0;
  endtask

  initial begin
    reset = 1;
    clr();
    ic_req_addr = IC_ADDR; ic_req_data_bits = IC_WD; ic_req_data_mask = IC_MK;
    dc_req_addr = DC_ADDR; dc_req_data_bits = DC_WD; dc_req_data_mask = DC_MK;

    // ---------------- table ----------------
    add(10'b1100100100, 9'b000000000, '0);       // 0 reset: everything quiet
    add(10'b1100100101, 9'b000000000, '0);       // 1 reset with response pulse
    add(10'b0100100100, 9'b101000000, DC_ADDR);  // 2 tie, rr_last=IC -> DC
    add(10'b0100100100, 9'b110000000, IC_ADDR);  // 3 -> IC
    add(10'b0100100101, 9'b101000010, DC_ADDR);  // 4 -> DC, resp to dc
    add(10'b0100100101, 9'b110000100, IC_ADDR);  // 5 -> IC, resp to ic
    add(10'b0000000001, 9'b000000010, '0);       // 6 resp to dc
    add(10'b0000000001, 9'b000000100, '0);       // 7 resp to ic
    add(10'b0000100100, 9'b101000000, DC_ADDR);  // 8 single dc read
    add(10'b0000000000, 9'b000000000, '0);       // 9
    add(10'b0000000000, 9'b000000000, '0);       // 10
    add(10'b0000000001, 9'b000000010, '0);       // 11 resp 3 cycles later
    add(10'b0000100000, 9'b100000000, DC_ADDR);  // 12 dc stalled -> HOLD dc
    add(10'b0100100100, 9'b101000000, DC_ADDR);  // 13 dc keeps lock over tie
    add(10'b0000000001, 9'b000000010, '0);       // 14 resp to dc
    add(10'b0111000010, 9'b100110000, IC_ADDR);  // 15 ic write, beat before request
    add(10'b0111000110, 9'b110000000, IC_ADDR);  // 16 request accepted, no second beat
    add(10'b0100111110, 9'b101101000, DC_ADDR);  // 17 dc write + beat same cycle
    add(10'b0000000001, 9'b000000000, '0);       // 18 response with empty FIFO
    add(10'b0000000000, 9'b000000001, '0);       // 19 sticky spurious
    add(10'b0000000000, 9'b000000001, '0);       // 20 still set

    for (int i = 0; i < vecs.size(); i++) begin
      tick();
      reset              = vecs[i].rst;
      ic_req_valid       = vecs[i].icv;
      ic_req_rw          = vecs[i].icrw;
      ic_req_data_valid  = vecs[i].icdv;
      dc_req_valid       = vecs[i].dcv;
      dc_req_rw          = vecs[i].dcrw;
      dc_req_data_valid  = vecs[i].dcdv;
      mem_req_ready      = vecs[i].mrr;
      mem_req_data_ready = vecs[i].mdr;
      mem_resp_valid     = vecs[i].rspv;
      #1;
      chk($sformatf("row%0d mem_req_valid", i), DB'(mem_req_valid), DB'(vecs[i].e_mv));
      chk($sformatf("row%0d ic_req_ready", i), DB'(ic_req_ready), DB'(vecs[i].e_icr));
      chk($sformatf("row%0d dc_req_ready", i), DB'(dc_req_ready), DB'(vecs[i].e_dcr));
      chk($sformatf("row%0d mem_req_data_valid", i), DB'(mem_req_data_valid), DB'(vecs[i].e_mdv));
      chk($sformatf("row%0d ic_req_data_ready", i), DB'(ic_req_data_ready), DB'(vecs[i].e_icdr));
      chk($sformatf("row%0d dc_req_data_ready", i), DB'(dc_req_data_ready), DB'(vecs[i].e_dcdr));
      chk($sformatf("row%0d ic_resp_valid", i), DB'(ic_resp_valid), DB'(vecs[i].e_icrv));
      chk($sformatf("row%0d dc_resp_valid", i), DB'(dc_resp_valid), DB'(vecs[i].e_dcrv));
      chk($sformatf("row%0d spurious_resp", i), DB'(spurious_resp), DB'(vecs[i].e_sp));
      if (vecs[i].e_mv)
        chk($sformatf("row%0d mem_req_addr", i), DB'(mem_req_addr), DB'(vecs[i].e_addr));
    end

    // ---------------- seq A: delayed write beat holds off ic ----------------
    do_reset();
    dc_req_valid = 1; dc_req_rw = 1; ic_req_valid = 1;
    mem_req_ready = 1; mem_req_data_ready = 1;
    #1;
    chk("A spurious cleared by reset", DB'(spurious_resp), DB'(0));
    chk("A dc write granted", DB'(dc_req_ready), DB'(1));
    chk("A ic not granted", DB'(ic_req_ready), DB'(0));
    chk("A mem_req_rw", DB'(mem_req_rw), DB'(1));
    for (int c = 0; c < 3; c++) begin
      tick();
      dc_req_valid = 0; ic_req_data_valid = 1;
      #1;
      chk($sformatf("A wdata%0d ic_req_ready", c), DB'(ic_req_ready), DB'(0));
      chk($sformatf("A wdata%0d mem_req_valid", c), DB'(mem_req_valid), DB'(0));
      chk($sformatf("A wdata%0d mem_req_data_valid", c), DB'(mem_req_data_valid), DB'(0));
      chk($sformatf("A wdata%0d ic_req_data_ready", c), DB'(ic_req_data_ready), DB'(0));
    end
    tick();
    dc_req_data_valid = 1;
    #1;
    chk("A beat valid", DB'(mem_req_data_valid), DB'(1));
    chk("A beat dc ready", DB'(dc_req_data_ready), DB'(1));
    chk("A beat bits", mem_req_data_bits, DC_WD);
    chk("A beat mask", DB'(mem_req_data_mask), DB'(DC_MK));
    chk("A beat ic still blocked", DB'(ic_req_ready), DB'(0));
    tick();
    dc_req_data_valid = 0; ic_req_data_valid = 0;
    #1;
    chk("A ic granted after beat", DB'(ic_req_ready), DB'(1));
    chk("A ic addr", DB'(mem_req_addr), DB'(IC_ADDR));

    // ---------------- seq B: tag FIFO full ----------------
    do_reset();
    ic_req_valid = 1; mem_req_ready = 1; mem_req_data_ready = 1;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) tick();
      #1;
      chk($sformatf("B read%0d granted", c), DB'(ic_req_ready), DB'(1));
    end
    tick();
    dc_req_valid = 1; dc_req_rw = 1; dc_req_data_valid = 1;
    #1;
    chk("B write granted when full", DB'(dc_req_ready), DB'(1));
    chk("B write beat", DB'(dc_req_data_ready), DB'(1));
    chk("B 5th read not granted", DB'(ic_req_ready), DB'(0));
    tick();
    dc_req_valid = 0; dc_req_data_valid = 0;
    #1;
    chk("B 5th read blocked", DB'(mem_req_valid), DB'(0));
    tick();
    mem_resp_valid = 1;
    #1;
    chk("B resp to ic", DB'(ic_resp_valid), DB'(1));
    chk("B no pop bypass", DB'(mem_req_valid), DB'(0));
    tick();
    mem_resp_valid = 0;
    #1;
    chk("B 5th read issued", DB'(mem_req_valid), DB'(1));
    chk("B 5th read ready", DB'(ic_req_ready), DB'(1));

    // ---------------- seq C: reset in WDATA with reads in flight ----------------
    do_reset();
    dc_req_valid = 1; mem_req_ready = 1; mem_req_data_ready = 1;
    #1; chk("C read0", DB'(dc_req_ready), DB'(1));
    tick(); #1; chk("C read1", DB'(dc_req_ready), DB'(1));
    tick(); dc_req_rw = 1; #1; chk("C write", DB'(dc_req_ready), DB'(1));
    tick();
    reset = 1; ic_req_valid = 1; ic_req_data_valid = 1; dc_req_data_valid = 1;
    mem_resp_valid = 1;
    #1;
    chk("C rst ic_req_ready", DB'(ic_req_ready), DB'(0));
    chk("C rst dc_req_ready", DB'(dc_req_ready), DB'(0));
    chk("C rst mem_req_valid", DB'(mem_req_valid), DB'(0));
    chk("C rst mem_req_data_valid", DB'(mem_req_data_valid), DB'(0));
    chk("C rst dc_req_data_ready", DB'(dc_req_data_ready), DB'(0));
    chk("C rst ic_req_data_ready", DB'(ic_req_data_ready), DB'(0));
    chk("C rst dc_resp_valid", DB'(dc_resp_valid), DB'(0));
    tick();
    reset = 0; dc_req_valid = 0; dc_req_rw = 0; dc_req_data_valid = 0;
    ic_req_data_valid = 0;
    #1;
    chk("C idle after reset", DB'(ic_req_ready), DB'(1));
    chk("C old tags gone dc", DB'(dc_resp_valid), DB'(0));
    chk("C old tags gone ic", DB'(ic_resp_valid), DB'(0));
    tick();
    ic_req_valid = 0; mem_resp_data = RSP_D;
    #1;
    chk("C fresh read resp", DB'(ic_resp_valid), DB'(1));
    chk("C fresh read dc quiet", DB'(dc_resp_valid), DB'(0));
    chk("C resp data", ic_resp_data, RSP_D);
    chk("C spurious after reset", DB'(spurious_resp), DB'(1));
    tick();
    clr();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sits directly downstream of the instruction cache and the data cache. Merges their two memory-side ports onto the single main-memory port.
- Each cache port carries a request channel, a write-data channel and a read-response channel.
- Arbitrates request ownership round-robin and keeps a write's data beat bound to the request owner.
- Records the issuing client of every read in an in-order tag FIFO, so each memory response returns to the correct cache.

Parameters:
ADDR_BITS, 28, line-granular memory address width
DATA_BITS, 128, memory beat width
MAX_OUTSTANDING, 4, max in-flight reads (tag FIFO depth, power of 2)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
ic_req_valid  in  1  icache request valid
ic_req_ready  out  1  icache request accepted
ic_req_addr  in  ADDR_BITS  icache request address
ic_req_rw  in  1  1=write, 0=read
ic_req_data_valid  in  1  icache write beat valid
ic_req_data_ready  out  1  icache write beat accepted
ic_req_data_bits  in  DATA_BITS  icache write data
ic_req_data_mask  in  DATA_BITS/8  icache byte mask
ic_resp_valid  out  1  read response to icache
ic_resp_data  out  DATA_BITS  read response data
dc_* (10 ports)  —  —  identical set for dcache
mem_req_valid  out  1  to memory
mem_req_ready  in  1  memory accepts request
mem_req_addr  out  ADDR_BITS  forwarded address
mem_req_rw  out  1  forwarded rw
mem_req_data_valid  out  1  forwarded write beat valid
mem_req_data_ready  in  1  memory accepts beat
mem_req_data_bits  out  DATA_BITS  forwarded data
mem_req_data_mask  out  DATA_BITS/8  forwarded mask
mem_resp_valid  in  1  in-order read response, no backpressure
mem_resp_data  in  DATA_BITS  response data
spurious_resp  out  1  sticky: response arrived with tag FIFO empty

Behaviour:
- Reset (synchronous, active-high, clock clk):
  - state=IDLE, owner cleared, rr_last=IC so DC wins the first tie.
  - Tag FIFO emptied, spurious_resp=0.
  - All valid and ready outputs 0 in the reset cycle.
- Reset mid-operation discards locks and in-flight tags. Later responses with an empty FIFO set spurious_resp.
- States: IDLE, HOLD, WDATA.
- IDLE:
  - Select owner from the valid requesters. If both are valid, pick the one that is not rr_last.
  - Present owner's addr/rw on the mem_req_* ports. mem_req_valid = owner valid AND NOT (rw=0 AND FIFO full). full is computed from the registered count; there is no pop bypass.
  - owner_req_ready = mem_req_ready AND that gating; the non-owner sees ready=0.
  - On handshake: rr_last<=owner.
    - Read: push owner tag, stay IDLE.
    - Write with a data handshake in the same cycle: stay IDLE.
    - Write without a same-cycle data handshake: go to WDATA.
  - No handshake and owner valid: go to HOLD with owner latched.
- HOLD:
  - Owner stays latched; the other client is blocked even if it is valid.
  - On handshake, apply the IDLE handshake actions.
  - Owner valid dropping without a handshake is a protocol error; return to IDLE.
- WDATA:
  - No new requests are accepted (both req_ready=0).
  - Only owner's data channel is connected: mem_req_data_valid = owner data_valid; owner data_ready = mem_req_data_ready.
  - On data handshake, go to IDLE.
- Data channel in IDLE/HOLD:
  - Forwarded only for the current owner, and only when owner rw=1.
  - The data handshake may precede the request handshake. That beat is recorded, and the request handshake then returns to IDLE.
- Non-owner data_ready=0 always.
- Responses:
  - ic_resp_valid = mem_resp_valid AND !empty AND head==IC; dc likewise.
  - resp_data wired to mem_resp_data for both clients, zero latency.
  - Pop on mem_resp_valid when !empty.
  - mem_resp_valid with empty FIFO: both resp_valid=0, set spurious_resp.
- FIFO: count width log2(MAX)+1. Pointers wrap modulo MAX. Simultaneous push and pop leaves count unchanged and preserves order.

Test Plan:
- Single dc read 0x000_0040, mem_req_ready=1 → mem_req_valid=1 with addr 0x0000040, rw=0, dc_req_ready=1 the same cycle; 3 cycles later mem_resp 0xDEAD.. → dc_resp_valid=1, ic_resp_valid=0.
- ic and dc reads both valid every cycle, ready=1, responses each returning 2 cycles later → grants alternate DC,IC,DC,IC; the 4 responses route to dc,ic,dc,ic in issue order.
- dc write with data_valid delayed 3 cycles after request handshake, ic read pending → state WDATA for 3 cycles, ic_req_ready=0 throughout; after the data handshake the ic read is granted.
- 4 ic reads issued, no responses → 5th read sees mem_req_valid=0; a dc write is still granted. After 1 response, the 5th read is issued the following cycle.
- mem_resp_valid pulse with no outstanding reads → no resp_valid; spurious_resp=1 and stays set until reset.
- Reset asserted while in WDATA with 2 reads outstanding → next cycle state IDLE, count=0, all readies 0 during reset; a subsequent fresh read completes normally.
